// File: rtl/gpio_bus_int.sv
// gpio_bus_int: GPIO slave on the ICE byte bus ('g' read pins, 'G' write latch, 'D' direction); request rises 1 cycle after frame end,
// sl_data/sl_data_latch follow grant/overflow combinationally so a stalled byte is simply held; GPIO_EVT_EN adds pin-change 'e' frames.
module gpio_bus_int #(
    parameter int N_GPIO = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              generate_nak,
    input  logic [7:0]        ma_data,
    input  logic [7:0]        ma_addr,
    input  logic              ma_data_valid,
    input  logic              ma_frame_valid,
    input  logic              sl_overflow,
    output logic [7:0]        sl_data,
    output logic              sl_arb_request,
    input  logic              sl_arb_grant,
    output logic              sl_data_latch,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_oe
);
    localparam int NB   = (N_GPIO + 7) / 8;
    localparam int W    = NB * 8;
    localparam int MAXB = 1 + 2 * NB;
    localparam int TW   = MAXB * 8;
    localparam int CW   = $clog2(NB + 2);
    localparam int LW   = $clog2(MAXB + 1);

    localparam logic [7:0] CMD_RD  = 8'h67;
    localparam logic [7:0] CMD_WR  = 8'h47;
    localparam logic [7:0] CMD_DIR = 8'h44;

    typedef enum logic [1:0] {IDLE, RECV, REQ, SEND} state_t;

    state_t            state;
    logic [N_GPIO-1:0] gpio_meta;
    logic [N_GPIO-1:0] gpio_sync;
    logic              fv_q;
    logic              req_q;
    logic [7:0]        cmd;
    logic [W-1:0]      stage;
    logic [CW-1:0]     cnt;
    logic [TW-1:0]     tx_sh;
    logic [LW-1:0]     tx_left;
    logic [W-1:0]      in_word;
    logic              frame_rise;
    logic              frame_fall;
    logic              known_cmd;
    logic              good_len;
    logic              granted;
    logic              latch;

    assign in_word    = W'(gpio_sync);
    assign frame_rise = ma_frame_valid & ~fv_q;
    assign frame_fall = ~ma_frame_valid & fv_q;
    assign known_cmd  = (ma_addr == CMD_RD) || (ma_addr == CMD_WR) || (ma_addr == CMD_DIR);
    assign good_len   = (cnt == CW'(NB));
    assign granted    = req_q & sl_arb_grant;
    assign latch      = granted & ~sl_overflow;

    // The slave bus is OR-combined, so drive zero unless we own it.
    assign sl_arb_request = req_q;
    assign sl_data        = granted ? tx_sh[TW-1 -: 8] : 8'h00;
    assign sl_data_latch  = latch;

`ifdef GPIO_EVT_EN
    logic [N_GPIO-1:0] evt_prev;
    logic [N_GPIO-1:0] evt_mask;
    logic [N_GPIO-1:0] evt_snap;
    logic [N_GPIO-1:0] evt_change;
    logic              tx_evt;
    logic              evt_pending;
    logic              first_evt_latch;

    assign evt_change      = (gpio_sync ^ evt_prev) & ~gpio_oe;
    assign evt_pending     = |evt_mask;
    assign first_evt_latch = latch && tx_evt && (tx_left == LW'(MAXB));

    // Only the bits already reported are cleared; later changes carry to the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_prev <= '0;
            evt_mask <= '0;
        end else begin
            evt_prev <= gpio_sync;
            evt_mask <= (first_evt_latch ? (evt_mask & ~evt_snap) : evt_mask) | evt_change;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gpio_meta <= '0;
            gpio_sync <= '0;
            fv_q      <= 1'b0;
            req_q     <= 1'b0;
            cmd       <= '0;
            stage     <= '0;
            cnt       <= '0;
            tx_sh     <= '0;
            tx_left   <= '0;
            gpio_out  <= '0;
            gpio_oe   <= '0;
`ifdef GPIO_EVT_EN
            tx_evt    <= 1'b0;
            evt_snap  <= '0;
`endif
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
            fv_q      <= ma_frame_valid;
            case (state)
                IDLE: begin
                    if (frame_rise && known_cmd && !generate_nak) begin
                        state <= RECV;
                        cmd   <= ma_addr;
                        stage <= ma_data_valid ? W'(ma_data) : '0;
                        cnt   <= ma_data_valid ? CW'(1) : '0;
                    end
`ifdef GPIO_EVT_EN
                    else if (evt_pending) begin
                        state    <= REQ;
                        req_q    <= 1'b1;
                        tx_evt   <= 1'b1;
                        evt_snap <= evt_mask;
                        tx_sh    <= {8'h65, in_word, W'(evt_mask)};
                        tx_left  <= LW'(MAXB);
                    end
`endif
                end
                RECV: begin
                    if (generate_nak) begin
                        state <= IDLE;
                    end else begin
                        if (ma_data_valid) begin
                            stage <= (stage << 8) | W'(ma_data);
                            if (cnt != CW'(NB + 1)) cnt <= cnt + 1'b1;
                        end
                        if (frame_fall) begin
                            state <= REQ;
                            req_q <= 1'b1;
`ifdef GPIO_EVT_EN
                            tx_evt <= 1'b0;
`endif
                            if (cmd == CMD_RD) begin
                                tx_sh   <= {8'h00, in_word, {W{1'b0}}};
                                tx_left <= LW'(NB + 1);
                            end else begin
                                tx_sh   <= {(good_len ? 8'h00 : 8'h01), {(TW-8){1'b0}}};
                                tx_left <= LW'(1);
                                if (good_len && cmd == CMD_WR)  gpio_out <= stage[N_GPIO-1:0];
                                if (good_len && cmd == CMD_DIR) gpio_oe  <= stage[N_GPIO-1:0];
                            end
                        end
                    end
                end
                default: begin
                    // REQ and SEND share the send logic; request low here means the last byte went out.
                    if (!req_q) begin
                        state <= IDLE;
                    end else begin
                        if (granted) state <= SEND;
                        if (latch) begin
                            tx_sh   <= tx_sh << 8;
                            tx_left <= tx_left - 1'b1;
                            if (tx_left == LW'(1)) req_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_bus_int.sv
// Bench for gpio_bus_int: command vector table plus hand-written stall, reset and event sequences.
`timescale 1ns/1ps
module tb_gpio_bus_int;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         generate_nak = 1'b0;
    logic [7:0]   ma_data = 8'h00;
    logic [7:0]   ma_addr = 8'h00;
    logic         ma_data_valid = 1'b0;
    logic         ma_frame_valid = 1'b0;
    logic         sl_overflow = 1'b0;
    logic [7:0]   sl_data;
    logic         sl_arb_request;
    logic         sl_arb_grant = 1'b0;
    logic         sl_data_latch;
    logic [N-1:0] gpio_in = '0;
    logic [N-1:0] gpio_out;
    logic [N-1:0] gpio_oe;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    logic [1:0] hist = 2'b00;

    typedef struct {
        logic [7:0] addr;
        int         n;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] gin;
        bit         abort;
        int         rn;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] exp_out;
        logic [7:0] exp_oe;
    } vec_t;

    gpio_bus_int #(.N_GPIO(N)) dut (
        .clk(clk), .rst(rst), .generate_nak(generate_nak),
        .ma_data(ma_data), .ma_addr(ma_addr), .ma_data_valid(ma_data_valid),
        .ma_frame_valid(ma_frame_valid), .sl_overflow(sl_overflow),
        .sl_data(sl_data), .sl_arb_request(sl_arb_request), .sl_arb_grant(sl_arb_grant),
        .sl_data_latch(sl_data_latch), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe)
    );

    always #25 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus controller model: grant two cycles after the request is seen.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            sl_arb_grant = sl_arb_request & hist[0] & hist[1];
            hist = {hist[0], sl_arb_request};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (sl_data_latch) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_latch: got %0h expected no byte", sl_data);
                end else begin
                    chk("resp_byte", {24'h0, sl_data}, {24'h0, sb.pop_front()});
                end
            end
            if (!sl_arb_grant) chk("ungranted_data_zero", {24'h0, sl_data}, 32'h0);
        end
    end

    task automatic drive_frame(input logic [7:0] addr, input int n, input logic [7:0] p0,
                               input logic [7:0] p1, input bit abort);
        @(posedge clk); #1;
        ma_addr = addr;
        ma_frame_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ma_data = (i == 0) ? p0 : p1;
            ma_data_valid = 1'b1;
            @(posedge clk); #1;
            ma_data_valid = 1'b0;
        end
        if (abort) begin
            @(posedge clk); #1; generate_nak = 1'b1;
            @(posedge clk); #1; generate_nak = 1'b0;
        end
        @(posedge clk); #1;
        ma_frame_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !sl_arb_request) break;
        end
        repeat (3) @(negedge clk);
        chk({name, "_drained"}, sb.size(), 32'd0);
        chk({name, "_req_low"}, {31'h0, sl_arb_request}, 32'd0);
    endtask

    task automatic wait_first_byte(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk); #1;
            got = (sb.size() == 1);
        end
        chk(name, {31'h0, got}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        gpio_in = v.gin;
        repeat (3) @(posedge clk);
        if (v.rn > 0) sb.push_back(v.r0);
        if (v.rn > 1) sb.push_back(v.r1);
        drive_frame(v.addr, v.n, v.p0, v.p1, v.abort);
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_req_latency", idx), {31'h0, sl_arb_request}, (v.rn > 0) ? 32'd1 : 32'd0);
        wait_done($sformatf("v%0d", idx));
        chk($sformatf("v%0d_gpio_out", idx), {24'h0, gpio_out}, {24'h0, v.exp_out});
        chk($sformatf("v%0d_gpio_oe", idx), {24'h0, gpio_oe}, {24'h0, v.exp_oe});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[10];
        vec_t rv;
        //           addr   n  p0     p1     gin    ab rn r0     r1     out    oe
        tbl[0] = '{8'h47, 1, 8'hA5, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 8'hA5, 8'h00};
        tbl[1] = '{8'h44, 2, 8'h0F, 8'hFF, 8'h00, 0, 1, 8'h01, 8'h00, 8'hA5, 8'h00};
        tbl[2] = '{8'h44, 1, 8'h0F, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 8'hA5, 8'h0F};
        tbl[3] = '{8'h47, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h01, 8'h00, 8'hA5, 8'h0F};
        tbl[4] = '{8'h67, 0, 8'h00, 8'h00, 8'h3C, 0, 2, 8'h00, 8'h3C, 8'hA5, 8'h0F};
        tbl[5] = '{8'h67, 1, 8'h55, 8'h00, 8'hC3, 0, 2, 8'h00, 8'hC3, 8'hA5, 8'h0F};
        tbl[6] = '{8'h78, 1, 8'h11, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'hA5, 8'h0F};
        tbl[7] = '{8'h47, 1, 8'hFF, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'hA5, 8'h0F};
        tbl[8] = '{8'h47, 2, 8'h12, 8'h34, 8'h00, 0, 1, 8'h01, 8'h00, 8'hA5, 8'h0F};
        tbl[9] = '{8'h47, 1, 8'h5A, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 8'h5A, 8'h0F};

        repeat (2) @(negedge clk);
        chk("rst_sl_data", {24'h0, sl_data}, 32'h0);
        chk("rst_request", {31'h0, sl_arb_request}, 32'h0);
        chk("rst_latch", {31'h0, sl_data_latch}, 32'h0);
        chk("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
        chk("rst_gpio_oe", {24'h0, gpio_oe}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

`ifdef GPIO_EVT_EN
        // Bit 2 rises on an input pin: event frame 'e', inputs, changed-mask.
        sb.push_back(8'h65); sb.push_back(8'h04); sb.push_back(8'h04);
        gpio_in = 8'h04;
        wait_done("evt_rise");
        // Bit 2 falls while a 'g' response is pending: 'g' first, then the event.
        sb.push_back(8'h00); sb.push_back(8'h04);
        sb.push_back(8'h65); sb.push_back(8'h00); sb.push_back(8'h04);
        drive_frame(8'h67, 0, 8'h00, 8'h00, 0);
        for (int k = 0; k < 10 && !sl_arb_request; k++) @(negedge clk);
        chk("evt_g_req", {31'h0, sl_arb_request}, 32'd1);
        gpio_in = 8'h00;
        wait_done("evt_after_g");
`else
        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // Overflow stall in the middle of a 'g' response.
        gpio_in = 8'h3C;
        repeat (3) @(posedge clk);
        sb.push_back(8'h00); sb.push_back(8'h3C);
        drive_frame(8'h67, 0, 8'h00, 8'h00, 0);
        wait_first_byte("ovf_first_byte");
        @(posedge clk); #1;
        sl_overflow = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ovf_no_latch", {31'h0, sl_data_latch}, 32'h0);
            chk("ovf_byte_held", {24'h0, sl_data}, 32'h3C);
        end
        @(posedge clk); #1;
        sl_overflow = 1'b0;
        wait_done("ovf");

        // Reset in the middle of SEND clears everything at once.
        sb.push_back(8'h00); sb.push_back(8'h3C);
        drive_frame(8'h67, 0, 8'h00, 8'h00, 0);
        wait_first_byte("mid_rst_first_byte");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_request", {31'h0, sl_arb_request}, 32'h0);
        chk("mid_rst_latch", {31'h0, sl_data_latch}, 32'h0);
        chk("mid_rst_gpio_out", {24'h0, gpio_out}, 32'h0);
        chk("mid_rst_gpio_oe", {24'h0, gpio_oe}, 32'h0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        rv = '{8'h67, 0, 8'h00, 8'h00, 8'h3C, 0, 2, 8'h00, 8'h3C, 8'h00, 8'h00};
        run_vec(rv, 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gpio_bus_int.md
Name: gpio_bus_int

Overview:
- Slave on the ICE master/slave byte bus, peer of the basics responder; one arbitration request/grant bit pair.
- Decodes GPIO commands from the master-driven bus: 'g' read pins, 'G' write output latch, 'D' write direction.
- Arbitrates for the slave output bus and returns ACK/NAK or read-data frames to the bus controller, which forwards them to the UART.

Parameters:
N_GPIO, 8, number of GPIO pins, 1..32
NB, (N_GPIO+7)/8, bytes per GPIO word on the bus; derived, not overridden

Ports:
clk  input  1  system clock (20 MHz)
rst  input  1  asynchronous active-high reset
generate_nak  input  1  one-cycle pulse; controller is NAKing the current frame itself
ma_data  input  8  master data byte
ma_addr  input  8  command char of current frame; stable while ma_frame_valid
ma_data_valid  input  1  one-cycle strobe; ma_data is valid
ma_frame_valid  input  1  high for the whole incoming frame
sl_overflow  input  1  controller cannot accept a byte this cycle
sl_data  output  8  response byte; 8'h00 whenever not granted (bus is OR-combined)
sl_arb_request  output  1  request for the slave output bus
sl_arb_grant  input  1  grant for this slave
sl_data_latch  output  1  one-cycle strobe; sl_data is valid
gpio_in  input  N_GPIO  pin levels, asynchronous to clk
gpio_out  output  N_GPIO  output latch
gpio_oe  output  N_GPIO  direction, 1 = drive

Behaviour:
- Reset values: sl_data=0, sl_arb_request=0, sl_data_latch=0, gpio_out=0, gpio_oe=0 (all pins inputs), FSM in IDLE.
- gpio_in passes through a 2-flop synchronizer. 'g' returns the synchronized value.
- Commands are recognized on the rising edge of ma_frame_valid with ma_addr in {8'h67 'g', 8'h47 'G', 8'h44 'D'}. Any other ma_addr: ignore the frame, no response.
- Payload bytes are shifted MSB-first into a staging register; the byte counter saturates at NB+1.
- Frame end is the falling edge of ma_frame_valid.
  - 'G' or 'D' with exactly NB payload bytes: commit the staging register to gpio_out or gpio_oe on the frame-end cycle, then respond with the single byte 8'h00 (ACK).
  - 'G' or 'D' with any other count: registers unchanged; respond 8'h01 (NAK).
  - 'g': respond 8'h00 followed by NB bytes of the synchronized inputs captured at frame end, MSB byte first, with unused high bits 0. Any payload bytes are ignored.
- generate_nak pulse during a frame aborts it: no commit, no response, return to IDLE.
- FSM states: IDLE -> RECV (frame start with a known command) -> REQ (frame end) -> SEND (sl_arb_grant high) -> IDLE.
  - REQ: sl_arb_request=1, waiting for grant.
  - SEND: one byte per cycle; sl_data_latch pulses only in cycles where sl_overflow=0. A stalled byte is held and not counted.
  - After the last byte's latch cycle, drop sl_arb_request; the next cycle returns to IDLE.
- sl_arb_request stays high from REQ entry until the last byte is latched. If grant drops mid-SEND, pause (no latch) and keep requesting.
- A new frame arriving while in REQ or SEND is ignored, with no queueing.
- rst asserted mid-operation returns everything to reset values immediately, including dropping sl_arb_request.
- Latency: sl_arb_request rises 1 cycle after the frame-end cycle. The first sl_data_latch occurs in the first cycle with grant=1 and overflow=0.

Optional Feature:
- GPIO_EVT_EN defined:
  - An input pin with gpio_oe=0 that changes (synchronized, edge-detected) sets a pending-event flag and ORs the change into a changed-mask.
  - From IDLE only, a pending event triggers an event frame: 8'h65 ('e'), then NB bytes of current inputs, then NB bytes of the changed-mask.
  - The changed-mask clears as the frame's first byte is latched. Changes arriving during the frame accumulate for the next event frame.
  - A command response takes priority over an event when both become eligible in the same cycle.
- GPIO_EVT_EN undefined: no edge logic; 'e' is never emitted.

Test Plan:
- N_GPIO=8; frame 'G' with payload 8'hA5; grant 2 cycles after request -> gpio_out=8'hA5 on frame end; one sl_data_latch with 8'h00; request drops after it.
- 'D' with two bytes (8'h0F, 8'hFF) -> gpio_oe stays 8'h00; response 8'h01.
- gpio_in=8'h3C, frame 'g' with no payload, sl_overflow high for 3 cycles mid-response -> latched bytes 8'h00, 8'h3C; no latch while overflow is high; sl_data=0 when not granted.
- 'G' frame with 8'hFF and generate_nak pulsed before frame end -> gpio_out unchanged; sl_arb_request never asserts. Frame with ma_addr 'x' -> no response.
- rst asserted while in SEND after the first byte -> sl_arb_request, gpio_out and gpio_oe go to 0 immediately; the next 'g' responds normally.
- GPIO_EVT_EN, N_GPIO=8, gpio_oe=8'h00: gpio_in bit 2 toggles 0->1 -> event frame 8'h65, 8'h04, 8'h04. If the same toggle coincides with a 'g' response, the 'g' response is sent first, then the event frame.
